// File: rtl/ramp_wavegen_multich_if.sv
// Bundle of the sample strobe, run levels, configuration bus and sample stream for
// ramp_wavegen_multich.
//   master : drives en, run and cfg_* and observes out_data/out_valid/done
//            (register block / test harness side)
//   slave  : the generator itself
// Parameters must match the ones given to the generator instance.
interface ramp_wavegen_multich_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 12,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                     en;
    logic [NUM_CH-1:0]        run;
    logic                     cfg_wr;
    logic [CH_W-1:0]          cfg_ch;
    logic [1:0]               cfg_shape;
    logic [ACC_W-1:0]         cfg_phase_inc;
    logic [DATA_W-1:0]        cfg_amp;
    logic [DATA_W-1:0]        cfg_offset;
    logic [CNT_W-1:0]         cfg_cycles;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic                     out_valid;
    logic [NUM_CH-1:0]        done;

    modport master (
        output en, run, cfg_wr, cfg_ch, cfg_shape, cfg_phase_inc, cfg_amp, cfg_offset, cfg_cycles,
        input  out_data, out_valid, done
    );

    modport slave (
        input  en, run, cfg_wr, cfg_ch, cfg_shape, cfg_phase_inc, cfg_amp, cfg_offset, cfg_cycles,
        output out_data, out_valid, done
    );
endinterface

// File: rtl/ramp_wavegen_multich.sv
// N-channel sawtooth / ramp-down / triangle generator feeding signed DAC sample streams.
// Each channel owns a phase accumulator, a period counter, a shadow and an active
// configuration set and an IDLE/RUN/DONE state machine. Samples pass through a two-stage
// pipeline (shape+scale, then offset+saturate), so an en in cycle k yields out_valid in k+2.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   bus      slave side of ramp_wavegen_multich_if:
//            en (sample strobe), run[NUM_CH], cfg_* write port,
//            out_data[NUM_CH*DATA_W] (channel c at [c*DATA_W +: DATA_W]), out_valid, done[NUM_CH]
module ramp_wavegen_multich #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 12,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    ramp_wavegen_multich_if.slave bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [DATA_W-1:0]        MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W:0]          AMP_FS   = {2'b01, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W:0]   SAT_MAX  = {2'b00, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W:0]   SAT_MIN  = {2'b11, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef struct packed {
        logic [1:0]        shape;
        logic [ACC_W-1:0]  inc;
        logic [DATA_W-1:0] amp;
        logic [DATA_W-1:0] offset;
        logic [CNT_W-1:0]  cycles;
    } cfg_t;

    state_e                   state_q   [NUM_CH];
    state_e                   state_d   [NUM_CH];
    logic [ACC_W-1:0]         acc_q     [NUM_CH];
    logic [ACC_W-1:0]         acc_d     [NUM_CH];
    logic [CNT_W-1:0]         cnt_q     [NUM_CH];
    logic [CNT_W-1:0]         cnt_d     [NUM_CH];
    cfg_t                     shadow_q  [NUM_CH];
    cfg_t                     shadow_d  [NUM_CH];
    cfg_t                     active_q  [NUM_CH];
    cfg_t                     active_d  [NUM_CH];
    logic [ACC_W:0]           acc_sum_s [NUM_CH];
    logic signed [DATA_W:0]   st1_y_q   [NUM_CH];
    logic signed [DATA_W:0]   st1_y_d   [NUM_CH];
    logic [DATA_W-1:0]        st1_off_q [NUM_CH];
    logic [DATA_W-1:0]        st1_off_d [NUM_CH];
    logic                     st1_vld_q;
    logic                     st1_vld_d;
    logic [NUM_CH*DATA_W-1:0] out_data_q;
    logic [NUM_CH*DATA_W-1:0] out_data_d;
    logic                     out_valid_q;
    logic                     out_valid_d;
    logic [NUM_CH-1:0]        done_q;
    logic [NUM_CH-1:0]        done_d;
    cfg_t                     wr_cfg_s;

    // Raw waveform value (offset binary flipped to two's complement) for the current phase.
    function automatic logic [DATA_W-1:0] shape_sample(input logic [1:0] shape,
                                                       input logic [ACC_W-1:0] acc);
        logic [DATA_W-1:0] ru;
        logic [DATA_W:0]   p;
        logic [DATA_W-1:0] u;
        ru = acc[ACC_W-1 -: DATA_W] ^ MSB_MASK;
        // Triangle folds the second half of the period back down using one extra phase bit.
        p  = acc[ACC_W-1 -: DATA_W+1];
        u  = p[DATA_W] ? ~p[DATA_W-1:0] : p[DATA_W-1:0];
        case (shape)
            2'b01:   shape_sample = ~ru;
            2'b10:   shape_sample = u ^ MSB_MASK;
            default: shape_sample = ru;
        endcase
    endfunction

    // Gain stage: amp is unsigned with full scale 2^(DATA_W-1); anything larger clamps.
    function automatic logic signed [DATA_W:0] scale_sample(input logic [DATA_W-1:0] r,
                                                            input logic [DATA_W-1:0] amp);
        logic [DATA_W:0]          amp_c;
        logic signed [2*DATA_W:0] prod;
        amp_c = ({1'b0, amp} > AMP_FS) ? AMP_FS : {1'b0, amp};
        prod  = $signed({{(DATA_W+1){r[DATA_W-1]}}, r}) * $signed({{DATA_W{1'b0}}, amp_c});
        prod  = prod >>> (DATA_W-1);
        return prod[DATA_W:0];
    endfunction

    // Offset add at DATA_W+1 bits cannot overflow, so saturation only needs a range compare.
    function automatic logic [DATA_W-1:0] offset_sat(input logic signed [DATA_W:0] y,
                                                     input logic [DATA_W-1:0]      off);
        logic signed [DATA_W:0] z;
        z = y + $signed({off[DATA_W-1], off});
        if (z > SAT_MAX) begin
            return SAT_MAX[DATA_W-1:0];
        end else if (z < SAT_MIN) begin
            return SAT_MIN[DATA_W-1:0];
        end else begin
            return z[DATA_W-1:0];
        end
    endfunction

    assign wr_cfg_s = {bus.cfg_shape, bus.cfg_phase_inc, bus.cfg_amp, bus.cfg_offset, bus.cfg_cycles};

    // Shadow register writes and accumulator adders with carry-out for wrap detection.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            // shadow_d doubles as the load source so a write in the load cycle is taken directly.
            if (bus.cfg_wr && (bus.cfg_ch == CH_W'(c))) begin
                shadow_d[c] = wr_cfg_s;
            end else begin
                shadow_d[c] = shadow_q[c];
            end
            acc_sum_s[c] = {1'b0, acc_q[c]} + {1'b0, active_q[c].inc};
        end
    end

    // Per-channel IDLE/RUN/DONE next-state logic; everything holds while en is low.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c]  = state_q[c];
            acc_d[c]    = acc_q[c];
            cnt_d[c]    = cnt_q[c];
            active_d[c] = active_q[c];
            if (bus.en) begin
                case (state_q[c])
                    ST_IDLE: begin
                        if (bus.run[c]) begin
                            state_d[c]  = ST_RUN;
                            acc_d[c]    = {ACC_W{1'b0}};
                            cnt_d[c]    = {CNT_W{1'b0}};
                            active_d[c] = shadow_d[c];
                        end else begin
                            state_d[c] = ST_IDLE;
                        end
                    end
                    ST_RUN: begin
                        if (!bus.run[c]) begin
                            state_d[c] = ST_IDLE;
                        end else begin
                            acc_d[c] = acc_sum_s[c][ACC_W-1:0];
                            if (acc_sum_s[c][ACC_W]) begin
                                cnt_d[c]    = cnt_q[c] + {{(CNT_W-1){1'b0}}, 1'b1};
                                active_d[c] = shadow_d[c];
                                if ((active_q[c].cycles != {CNT_W{1'b0}}) &&
                                    ((cnt_q[c] + {{(CNT_W-1){1'b0}}, 1'b1}) == active_q[c].cycles)) begin
                                    state_d[c] = ST_DONE;
                                end else begin
                                    state_d[c] = ST_RUN;
                                end
                            end else begin
                                state_d[c] = ST_RUN;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (!bus.run[c]) begin
                            state_d[c] = ST_IDLE;
                        end else begin
                            state_d[c] = ST_DONE;
                        end
                    end
                    default: begin
                        state_d[c] = ST_IDLE;
                    end
                endcase
            end else begin
                state_d[c] = state_q[c];
            end
            done_d[c] = (state_d[c] == ST_DONE);
        end
    end

    // Sample pipeline: stage 1 shapes and scales the pre-increment phase, stage 2 adds offset and saturates.
    always_comb begin
        st1_vld_d   = bus.en;
        out_valid_d = st1_vld_q;
        out_data_d  = out_data_q;
        for (int c = 0; c < NUM_CH; c++) begin
            st1_y_d[c]   = st1_y_q[c];
            st1_off_d[c] = st1_off_q[c];
            if (bus.en) begin
                // Non-running channels feed zero gain and zero offset so they emit 0.
                if (state_q[c] == ST_RUN) begin
                    st1_y_d[c]   = scale_sample(shape_sample(active_q[c].shape, acc_q[c]), active_q[c].amp);
                    st1_off_d[c] = active_q[c].offset;
                end else begin
                    st1_y_d[c]   = {(DATA_W+1){1'b0}};
                    st1_off_d[c] = {DATA_W{1'b0}};
                end
            end else begin
                st1_y_d[c]   = st1_y_q[c];
                st1_off_d[c] = st1_off_q[c];
            end
            if (st1_vld_q) begin
                out_data_d[c*DATA_W +: DATA_W] = offset_sat(st1_y_q[c], st1_off_q[c]);
            end else begin
                out_data_d[c*DATA_W +: DATA_W] = out_data_q[c*DATA_W +: DATA_W];
            end
        end
    end

    // State, configuration and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]   <= ST_IDLE;
                acc_q[c]     <= {ACC_W{1'b0}};
                cnt_q[c]     <= {CNT_W{1'b0}};
                shadow_q[c]  <= '0;
                active_q[c]  <= '0;
                st1_y_q[c]   <= {(DATA_W+1){1'b0}};
                st1_off_q[c] <= {DATA_W{1'b0}};
            end
            st1_vld_q   <= 1'b0;
            out_data_q  <= {(NUM_CH*DATA_W){1'b0}};
            out_valid_q <= 1'b0;
            done_q      <= {NUM_CH{1'b0}};
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]   <= state_d[c];
                acc_q[c]     <= acc_d[c];
                cnt_q[c]     <= cnt_d[c];
                shadow_q[c]  <= shadow_d[c];
                active_q[c]  <= active_d[c];
                st1_y_q[c]   <= st1_y_d[c];
                st1_off_q[c] <= st1_off_d[c];
            end
            st1_vld_q   <= st1_vld_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_ramp_wavegen_multich.sv
// Directed bench for ramp_wavegen_multich (NUM_CH=2, DATA_W=12, ACC_W=16, CNT_W=16).
// Inputs change 1 time unit after a rising edge; outputs are observed at the same point.
module tb_ramp_wavegen_multich;
    localparam int NUM_CH = 2;
    localparam int DATA_W = 12;
    localparam int ACC_W  = 16;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic signed [31:0] tri_tab [16] = '{-2048, -1536, -1024, -512, 0, 512, 1024, 1536,
                                         2047, 1535, 1023, 511, -1, -513, -1025, -1537};

    always #5 clk = ~clk;

    ramp_wavegen_multich_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    ramp_wavegen_multich #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] ch_val(input int c);
        logic [DATA_W-1:0] v;
        v = bus.out_data[c*DATA_W +: DATA_W];
        return {{(32-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    function automatic logic signed [31:0] sat12(input int v);
        if (v > 2047) return 32'sd2047;
        else if (v < -2048) return -32'sd2048;
        else return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_chk(input string tag, input logic signed [31:0] e0, input logic signed [31:0] e1);
        tick();
        check({tag, ".vld"}, {31'd0, bus.out_valid}, 32'sd1);
        check({tag, ".ch0"}, ch_val(0), e0);
        check({tag, ".ch1"}, ch_val(1), e1);
    endtask

    task automatic set_cfg(input logic ch, input logic [1:0] shape, input logic [15:0] inc,
                           input logic [11:0] amp, input logic [11:0] off, input logic [15:0] cyc);
        bus.cfg_wr        = 1'b1;
        bus.cfg_ch        = ch;
        bus.cfg_shape     = shape;
        bus.cfg_phase_inc = inc;
        bus.cfg_amp       = amp;
        bus.cfg_offset    = off;
        bus.cfg_cycles    = cyc;
    endtask

    task automatic write_cfg(input logic ch, input logic [1:0] shape, input logic [15:0] inc,
                             input logic [11:0] amp, input logic [11:0] off, input logic [15:0] cyc);
        set_cfg(ch, shape, inc, amp, off, cyc);
        tick();
        bus.cfg_wr = 1'b0;
    endtask

    // Return channels to IDLE, then start them; the first sample out is the IDLE zero.
    task automatic restart(input logic [1:0] runv, input string tag);
        bus.run = 2'b00;
        tick();
        tick();
        bus.run = runv;
        tick();
        tick_chk({tag, ".start"}, 32'sd0, 32'sd0);
    endtask

    initial begin
        rst               = 1'b1;
        bus.en            = 1'b0;
        bus.run           = 2'b00;
        bus.cfg_wr        = 1'b0;
        bus.cfg_ch        = 1'b0;
        bus.cfg_shape     = 2'b00;
        bus.cfg_phase_inc = 16'h0000;
        bus.cfg_amp       = 12'd0;
        bus.cfg_offset    = 12'd0;
        bus.cfg_cycles    = 16'd0;
        tick();
        tick();
        tick();
        check("rst.vld", {31'd0, bus.out_valid}, 32'sd0);
        check("rst.ch0", ch_val(0), 32'sd0);
        check("rst.ch1", ch_val(1), 32'sd0);
        check("rst.done", {30'd0, bus.done}, 32'sd0);
        rst = 1'b0;

        // 1: ramp-up, full scale, infinite; then en=0 freezes everything
        write_cfg(1'b0, 2'b00, 16'h1000, 12'd2048, 12'd0, 16'd0);
        bus.en  = 1'b1;
        bus.run = 2'b01;
        tick();
        check("t1.lat", {31'd0, bus.out_valid}, 32'sd0);
        tick_chk("t1.first", 32'sd0, 32'sd0);
        for (int i = 0; i < 32; i++) begin
            tick_chk($sformatf("t1[%0d]", i), -2048 + 256 * (i % 16), 32'sd0);
        end
        bus.en = 1'b0;
        tick();
        check("t1.frz_last_vld", {31'd0, bus.out_valid}, 32'sd1);
        check("t1.frz_last", ch_val(0), -32'sd2048);
        tick();
        check("t1.frz_vld0", {31'd0, bus.out_valid}, 32'sd0);
        tick();
        check("t1.frz_vld1", {31'd0, bus.out_valid}, 32'sd0);
        check("t1.frz_hold", ch_val(0), -32'sd2048);
        bus.en = 1'b1;
        tick();
        check("t1.resume_lat", {31'd0, bus.out_valid}, 32'sd0);
        tick_chk("t1.resume", -32'sd1792, 32'sd0);

        // 2: offset and saturation
        write_cfg(1'b0, 2'b00, 16'h1000, 12'd2048, 12'd1000, 16'd0);
        restart(2'b01, "t2p");
        for (int i = 0; i < 16; i++) begin
            tick_chk($sformatf("t2p[%0d]", i), sat12(-1048 + 256 * i), 32'sd0);
        end
        write_cfg(1'b0, 2'b00, 16'h1000, 12'd2048, 12'hC18, 16'd0);
        restart(2'b01, "t2n");
        for (int i = 0; i < 16; i++) begin
            tick_chk($sformatf("t2n[%0d]", i), sat12(-3048 + 256 * i), 32'sd0);
        end

        // 3: finite run of 3 periods, then DONE until run drops
        write_cfg(1'b0, 2'b00, 16'h4000, 12'd2048, 12'd0, 16'd3);
        restart(2'b01, "t3");
        for (int i = 0; i < 12; i++) begin
            tick_chk($sformatf("t3[%0d]", i), -2048 + 1024 * (i % 4), 32'sd0);
            check($sformatf("t3.done[%0d]", i), {30'd0, bus.done}, (i >= 10) ? 32'sd1 : 32'sd0);
        end
        for (int i = 0; i < 3; i++) begin
            tick_chk($sformatf("t3.after[%0d]", i), 32'sd0, 32'sd0);
            check($sformatf("t3.done_hold[%0d]", i), {30'd0, bus.done}, 32'sd1);
        end
        bus.run = 2'b00;
        tick();
        check("t3.done_clr", {30'd0, bus.done}, 32'sd0);

        // 4: amplitude change mid-period, then a write landing on the wrap cycle
        write_cfg(1'b0, 2'b00, 16'h1000, 12'd2048, 12'd0, 16'd0);
        restart(2'b01, "t4");
        for (int i = 0; i < 48; i++) begin
            if (i == 3) set_cfg(1'b0, 2'b00, 16'h1000, 12'd1024, 12'd0, 16'd0);
            if (i == 30) set_cfg(1'b0, 2'b00, 16'h1000, 12'd512, 12'd0, 16'd0);
            tick_chk($sformatf("t4[%0d]", i),
                     (i < 16) ? -2048 + 256 * (i % 16) :
                     (i < 32) ? -1024 + 128 * (i % 16) : -512 + 64 * (i % 16), 32'sd0);
            bus.cfg_wr = 1'b0;
        end

        // 5: ramp-down on ch0 alongside triangle on ch1
        write_cfg(1'b0, 2'b01, 16'h1000, 12'd2048, 12'd0, 16'd0);
        write_cfg(1'b1, 2'b10, 16'h1000, 12'd2048, 12'd0, 16'd0);
        restart(2'b11, "t5");
        for (int i = 0; i < 32; i++) begin
            tick_chk($sformatf("t5[%0d]", i), 2047 - 256 * (i % 16), tri_tab[i % 16]);
        end

        // 6: reset while running, then run dropped mid-period and restarted
        rst     = 1'b1;
        bus.run = 2'b00;
        tick();
        tick();
        check("t6.rst_vld", {31'd0, bus.out_valid}, 32'sd0);
        check("t6.rst_ch0", ch_val(0), 32'sd0);
        check("t6.rst_ch1", ch_val(1), 32'sd0);
        check("t6.rst_done", {30'd0, bus.done}, 32'sd0);
        rst = 1'b0;
        tick();
        check("t6.post_rst_vld", {31'd0, bus.out_valid}, 32'sd0);
        tick_chk("t6.post_rst", 32'sd0, 32'sd0);
        write_cfg(1'b0, 2'b00, 16'h1000, 12'd2048, 12'd0, 16'd0);
        restart(2'b01, "t6");
        for (int i = 0; i < 5; i++) begin
            tick_chk($sformatf("t6[%0d]", i), -2048 + 256 * i, 32'sd0);
        end
        bus.run = 2'b00;
        tick_chk("t6.drop_inflight", -32'sd768, 32'sd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick_chk($sformatf("t6.idle[%0d]", i), 32'sd0, 32'sd0);
        end
        bus.run = 2'b01;
        tick();
        tick_chk("t6.re_idle", 32'sd0, 32'sd0);
        tick_chk("t6.re0", -32'sd2048, 32'sd0);
        tick_chk("t6.re1", -32'sd1792, 32'sd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
